sirv_gnrl_pipe_lrs_val: RTL
===========================

Name: sirv_gnrl_pipe_lrs_val

Overview:
- Parametrised elastic pipeline register: DEPTH stages of DW-bit data, each stage with its own valid flag, valid/ready handshake on both sides, synchronous flush, and a per-instance reset value.
- Successor to the single load-enable/reset-value flop. Used wherever a datapath needs N register slices that can stall under backpressure without dropping or duplicating beats.

Parameters:
DW, 32, data width in bits (>=1)
DEPTH, 2, number of register stages (>=0; 0 = combinational pass-through)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous assert, active-high
rst_v  input  DW  reset value loaded into every stage data register; must be stable while rst is high
flush  input  1  synchronous flush; clears all stage valids
i_vld  input  1  upstream beat valid
i_rdy  output  1  pipeline can accept a beat this cycle
i_dat  input  DW  upstream data
o_vld  output  1  last stage holds a valid beat
o_rdy  input  1  downstream accepts the beat
o_dat  output  DW  last stage data

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- State: vld[k] (1 bit) and dat[k] (DW bits) for k = 0..DEPTH-1. Stage 0 is nearest the input.
- Reset (rst=1, asynchronous): all vld[k]=0 and all dat[k]=rst_v. Consequently o_vld=0 and o_dat=rst_v. i_rdy=1 while flush=0.
- Ready chain: rdy_in[DEPTH]=o_rdy; rdy_in[k] = ~vld[k] | rdy_in[k+1]; i_rdy = rdy_in[0] & ~flush. The chain is combinational, so o_rdy to i_rdy is a combinational path of depth DEPTH.
- Stage load: ld[k] = rdy_in[k] & src_vld, where src_vld = i_vld for k=0, else vld[k-1].
  - On ld[k]: dat[k] <= source data.
  - Otherwise dat[k] holds.
  - Data registers never load on bubbles.
- Valid update (flush=0): vld[k] <= src_vld when rdy_in[k]; else vld[k] holds.
- Handshake rules:
  - A beat transfers at the input when i_vld & i_rdy, and at the output when o_vld & o_rdy.
  - Once o_vld=1, o_vld and o_dat stay stable until o_rdy=1.
  - i_vld may drop without a transfer.
- Latency and throughput: with o_rdy held at 1, a beat accepted in cycle t appears on o_vld/o_dat in cycle t+DEPTH. Sustained throughput is 1 beat/cycle.
- Full: all vld=1 and o_rdy=0 gives i_rdy=0. Full with o_rdy=1 gives i_rdy=1; every stage shifts and the input is accepted in the same cycle.
- Empty: o_vld=0. o_dat shows the last loaded or reset value and must be ignored.
- Flush: all vld[k] <= 0 at the next edge; dat unchanged. i_rdy=0 during flush, so no input is accepted. o_vld in the flush cycle still reflects the current state. An output transfer in that cycle (o_vld & o_rdy) is legal and counts as delivered.
- Simultaneous rst and flush: rst dominates.
- Reset asserted mid-operation: all in-flight beats are discarded immediately (asynchronous). After deassertion the pipeline behaves as if empty.
- DEPTH=0: o_vld=i_vld, o_dat=i_dat, i_rdy=o_rdy & ~flush, no state. When flush=1 the output view is also gated: o_vld=0.
- No beat is ever duplicated, reordered or dropped, except by flush or rst.

Optional Feature:
SIRV_GNRL_PIPE_CNT_EN
- Defined: adds output port o_cnt, width $clog2(DEPTH+1) (1 when DEPTH=0), equal to the registered count of valid stages.
  - Reset value 0.
  - Each cycle: +1 on input transfer, -1 on output transfer, unchanged when both occur.
  - Flush sets it to 0 at the next edge.
  - o_cnt must always equal popcount(vld).
- Undefined: no o_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: rst=1 asynchronously with DW=32, DEPTH=2, rst_v=0xDEADBEEF -> o_vld=0, o_dat=0xDEADBEEF, i_rdy=1, immediately (no clock needed).
- Streaming: o_rdy=1, drive beats 0x1,0x2,0x3 in consecutive cycles from cycle 0 -> o_vld=1 with o_dat 0x1,0x2,0x3 in cycles 2,3,4; i_rdy=1 throughout.
- Backpressure: o_rdy=0, push 0xA,0xB -> i_rdy=0 after 2 beats and o_dat holds 0xA; raise o_rdy for 1 cycle -> 0xA delivered, 0xB on output next cycle, i_rdy=1 that cycle.
- Full pass-through: pipe full (0xA,0xB), o_rdy=1, i_vld=1, i_dat=0xC in the same cycle -> 0xA delivered and 0xC accepted; next cycles output 0xB then 0xC; no loss.
- Flush: pipe full, flush=1 for one cycle with i_vld=1 -> i_rdy=0 that cycle; next cycle o_vld=0, o_cnt=0 (if enabled), and the input beat was not captured.
- Mid-stream reset: 2 beats in flight, pulse rst -> o_vld=0 and o_dat=rst_v asynchronously; after release, beat 0x5 emerges 2 cycles after acceptance. DEPTH=0 instance: o_dat==i_dat and i_rdy==o_rdy combinationally.

Source files
------------

// File: rtl/sirv_gnrl_pipe_lrs_val.sv
// -----------------------------------------------------------------------------
// sirv_gnrl_pipe_lrs_val
//
// Elastic pipeline register. It has DEPTH stages of DW-bit data, and each stage
// has its own valid flag. Both sides use a valid/ready handshake. The block has
// a synchronous flush, and every stage data register resets to rst_v.
//
// Parameters
//   DW     data width in bits (>= 1)
//   DEPTH  number of register stages (>= 0, 0 = combinational pass-through)
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rst    in   asynchronous, active-high reset
//   rst_v  in   [DW]  reset value for every stage data register
//   flush  in   synchronous flush, drops every in-flight beat
//   i_vld  in   upstream beat valid
//   i_rdy  out  pipeline accepts a beat this cycle
//   i_dat  in   [DW]  upstream data
//   o_vld  out  last stage holds a valid beat
//   o_rdy  in   downstream accepts the beat
//   o_dat  out  [DW]  last stage data
//   o_cnt  out  [CW]  number of valid stages (only with SIRV_GNRL_PIPE_CNT_EN)
//
// Optional feature macro: SIRV_GNRL_PIPE_CNT_EN adds the o_cnt occupancy port.
// -----------------------------------------------------------------------------
module sirv_gnrl_pipe_lrs_val #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    localparam int CW   = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] rst_v,
    input  logic          flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
`ifdef SIRV_GNRL_PIPE_CNT_EN
    ,
    output logic [CW-1:0] o_cnt
`endif
);

`ifdef SIRV_GNRL_PIPE_CNT_EN
    // Next occupancy. Flush empties the pipe. A beat in plus a beat out in the
    // same cycle leaves the count unchanged.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cur,
                                               input logic          inc,
                                               input logic          dec,
                                               input logic          fl);
        if (fl) begin
            return '0;
        end
        case ({inc, dec})
            2'b10:   return cur + CW'(1);
            2'b01:   return cur - CW'(1);
            default: return cur;
        endcase
    endfunction
`endif

    generate
        if (DEPTH == 0) begin : g_pass
            // No storage: the handshake is wired straight through. Flush still
            // gates both directions, so nothing is transferred while it is high.
            assign o_vld = i_vld & ~flush;
            assign o_dat = i_dat;
            assign i_rdy = o_rdy & ~flush;

`ifdef SIRV_GNRL_PIPE_CNT_EN
            assign o_cnt = '0;
`endif

            logic unused_pass;
            assign unused_pass = ^{clk, rst, rst_v};
        end else begin : g_pipe
            logic [DEPTH-1:0] stg_vld;
            logic [DW-1:0]    stg_dat [DEPTH];

            // rdy_in[k]: stage k may take a new beat (or a bubble) at this edge.
            logic [DEPTH-1:0] rdy_in;
            logic [DEPTH-1:0] src_vld;
            logic [DW-1:0]    src_dat [DEPTH];
            logic [DEPTH-1:0] ld;

            // Ready ripples backwards from the output. An empty stage, or a
            // stage whose successor is moving, can load. This is a combinational
            // path of DEPTH gates from o_rdy to i_rdy.
            always_comb begin
                logic chain;
                rdy_in = '0;
                chain  = o_rdy;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    rdy_in[k] = ~stg_vld[k] | chain;
                    chain     = rdy_in[k];
                end
            end

            // The source of each stage is the previous stage. The source of
            // stage 0 is the input port.
            always_comb begin
                src_vld    = '0;
                src_vld[0] = i_vld;
                src_dat[0] = i_dat;
                for (int k = 1; k < DEPTH; k++) begin
                    src_vld[k] = stg_vld[k-1];
                    src_dat[k] = stg_dat[k-1];
                end
            end

            // Data moves only with a real beat. Flush freezes the data so that
            // the dropped beats leave the registers untouched.
            assign ld = rdy_in & src_vld & {DEPTH{~flush}};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg_vld <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        stg_dat[k] <= rst_v;
                    end
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (flush) begin
                            stg_vld[k] <= 1'b0;
                        end else if (rdy_in[k]) begin
                            stg_vld[k] <= src_vld[k];
                        end
                        if (ld[k]) begin
                            stg_dat[k] <= src_dat[k];
                        end
                    end
                end
            end

            assign o_vld = stg_vld[DEPTH-1];
            assign o_dat = stg_dat[DEPTH-1];
            assign i_rdy = rdy_in[0] & ~flush;

`ifdef SIRV_GNRL_PIPE_CNT_EN
            logic [CW-1:0] cnt_q;
            logic          in_xfer;
            logic          out_xfer;

            // i_rdy already includes ~flush, so a flush cycle never counts an
            // input beat.
            assign in_xfer  = i_vld & i_rdy;
            assign out_xfer = o_vld & o_rdy;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_next(cnt_q, in_xfer, out_xfer, flush);
                end
            end

            assign o_cnt = cnt_q;
`endif
        end
    endgenerate

endmodule
